// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter that sequences requests through a shared 8-bit ALU
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_sel,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_sel,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_data,
  output logic [3:0]  alu_sel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_fout,
  output logic        busy,
  output logic        grant_id
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  state_t      state_q, state_d;
  logic        ptr_q, ptr_d, grant_id_q, grant_id_d, grant, accept, rsp_ready_g;
  logic [3:0]  cnt_q, cnt_d, sel_q, sel_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] res_q, res_d;
  always_comb begin
    grant       = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    req0_ready  = !rst && state_q == IDLE && !grant && req0_valid;
    req1_ready  = !rst && state_q == IDLE && grant && req1_valid;
    accept      = req0_ready || req1_ready;
    rsp_ready_g = grant_id_q ? rsp1_ready : rsp0_ready;
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d    = EXEC;
        grant_id_d = grant;
        cnt_d      = 4'(SETTLE_CYCLES - 1);
        sel_d      = grant ? req1_sel : req0_sel;
        a_d        = grant ? req1_a : req0_a;
        b_d        = grant ? req1_b : req0_b;
      end
      EXEC: begin
        cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          res_d   = alu_fout;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready_g) begin
        state_d = IDLE;
        ptr_d   = ~grant_id_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      grant_id_q <= 1'b0;
      cnt_q      <= 4'd0;
      sel_q      <= 4'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      res_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
    end
  end
  // Result is broadcast on both ports; only the granted port's valid qualifies it.
  assign rsp0_valid = state_q == RESP && !grant_id_q;
  assign rsp1_valid = state_q == RESP && grant_id_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign alu_sel    = sel_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = state_q != IDLE;
  assign grant_id   = grant_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  localparam int S = 2;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [3:0] req0_sel = 0, req1_sel = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id;
  logic [15:0] rsp0_data, rsp1_data, alu_fout;
  logic [3:0] alu_sel;
  logic [7:0] alu_a, alu_b;
  logic req0_ready_4, req1_ready_4, rsp0_valid_4, rsp1_valid_4, busy_4, grant_id_4;
  logic [15:0] rsp0_data_4, rsp1_data_4, alu_fout_4;
  logic [3:0] alu_sel_4;
  logic [7:0] alu_a_4, alu_b_4;
  logic req0_ready_1, req1_ready_1, rsp0_valid_1, rsp1_valid_1, busy_1, grant_id_1;
  logic [15:0] rsp0_data_1, rsp1_data_1, alu_fout_1;
  logic [3:0] alu_sel_1;
  logic [7:0] alu_a_1, alu_b_1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      4'd0: return 16'(a) * 16'(b);
      4'd1: return 16'(a) + 16'(b);
      4'd2: return 16'(a) - 16'(b);
      4'd3: return {8'h00, a & b};
      4'd4: return {8'h00, a | b};
      4'd7: return {8'h00, a ^ b};
      4'd8: return {b, a};
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_fout   = alu_ref(alu_sel, alu_a, alu_b);
  assign alu_fout_4 = alu_ref(alu_sel_4, alu_a_4, alu_b_4);
  assign alu_fout_1 = alu_ref(alu_sel_1, alu_a_1, alu_b_1);

  alu_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_fout(alu_fout),
    .busy(busy), .grant_id(grant_id));

  alu_arbiter #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_4), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready_4), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid_4), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data_4),
    .rsp1_valid(rsp1_valid_4), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data_4),
    .alu_sel(alu_sel_4), .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_fout(alu_fout_4),
    .busy(busy_4), .grant_id(grant_id_4));

  alu_arbiter #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_1), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready_1), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid_1), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data_1),
    .rsp1_valid(rsp1_valid_1), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data_1),
    .alu_sel(alu_sel_1), .alu_a(alu_a_1), .alu_b(alu_b_1), .alu_fout(alu_fout_1),
    .busy(busy_1), .grant_id(grant_id_1));

  task automatic do_reset();
    rst = 1;
    req0_valid = 0;
    req1_valid = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    req0_valid = 1;
    req1_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready, req0_ready_4, req1_ready_4} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0000", {req0_ready, req1_ready, req0_ready_4, req1_ready_4});
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, busy, grant_id, alu_sel, alu_a, alu_b, rsp0_data, rsp1_data} !== 56'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {rsp0_valid, rsp1_valid, busy, grant_id, alu_sel, alu_a, alu_b, rsp0_data, rsp1_data});
    end
    rst = 0;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic test_single_add();
    int lat = -1, lat1 = -1;
    logic [15:0] d = 0, d1 = 0;
    logic saw1 = 0;
    do_reset();
    rsp0_ready = 1;
    rsp1_ready = 1;
    req0_valid = 1;
    req0_sel = 4'd1;
    req0_a = 8'd3;
    req0_b = 8'd4;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL add_ready got %b exp 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++;
    if ({busy, grant_id, alu_sel, alu_a, alu_b, rsp0_valid} !== {1'b1, 1'b0, 4'd1, 8'd3, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL add_exec got %h exp %h", {busy, grant_id, alu_sel, alu_a, alu_b, rsp0_valid}, {1'b1, 1'b0, 4'd1, 8'd3, 8'd4, 1'b0});
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid && lat < 0) begin lat = c; d = rsp0_data; end
      if (rsp0_valid_1 && lat1 < 0) begin lat1 = c; d1 = rsp0_data_1; end
      if (rsp1_valid || rsp1_valid_1) saw1 = 1;
      if (c == S + 1) begin
        checks++;
        if ({rsp0_valid, busy} !== 2'b00) begin
          errors++;
          $display("FAIL add_done got %b exp 00", {rsp0_valid, busy});
        end
      end
    end
    checks++;
    if (lat !== S || d !== 16'h0007) begin
      errors++;
      $display("FAIL add_rsp got lat %0d data %h exp lat %0d data 0007", lat, d, S);
    end
    checks++;
    if (lat1 !== 1 || d1 !== 16'h0007) begin
      errors++;
      $display("FAIL add_settle1 got lat %0d data %h exp lat 1 data 0007", lat1, d1);
    end
    checks++;
    if (saw1 !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp1_quiet got %b exp 0", saw1);
    end
  endtask

  task automatic test_simultaneous();
    int got = 0;
    logic acc0 = 0, acc1 = 0;
    logic order [2];
    logic [15:0] data [2];
    do_reset();
    rsp0_ready = 1;
    rsp1_ready = 1;
    req0_valid = 1; req0_sel = 4'd0; req0_a = 8'hFF; req0_b = 8'hFF;
    req1_valid = 1; req1_sel = 4'd7; req1_a = 8'hA5; req1_b = 8'h0F;
    #1;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (rsp0_valid) begin order[got] = 0; data[got] = rsp0_data; got++; end
      else if (rsp1_valid) begin order[got] = 1; data[got] = rsp1_data; got++; end
      acc0 |= req0_ready;
      acc1 |= req1_ready;
      @(negedge clk);
      if (acc0) req0_valid = 0;
      if (acc1) req1_valid = 0;
      #1;
    end
    checks++;
    if (got !== 2) begin
      errors++;
      $display("FAIL simul_count got %0d exp 2", got);
    end else begin
      checks++;
      if (order[0] !== 1'b0 || data[0] !== 16'hFE01) begin
        errors++;
        $display("FAIL simul_first got port %0d data %h exp port 0 data fe01", order[0], data[0]);
      end
      checks++;
      if (order[1] !== 1'b1 || data[1] !== 16'h00AA) begin
        errors++;
        $display("FAIL simul_second got port %0d data %h exp port 1 data 00aa", order[1], data[1]);
      end
    end
  endtask

  task automatic test_contention();
    int n = 0;
    logic g = 0, acc = 0;
    logic [15:0] exp_q [$];
    do_reset();
    rsp0_ready = 1;
    rsp1_ready = 1;
    req0_valid = 1; req0_sel = 4'($urandom_range(0, 8)); req0_a = 8'($urandom); req0_b = 8'($urandom);
    req1_valid = 1; req1_sel = 4'($urandom_range(0, 8)); req1_a = 8'($urandom); req1_b = 8'($urandom);
    #1;
    for (int c = 0; c < 6 * (S + 2) + 10 && n < 6; c++) begin
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL cont_both_ready got 11 exp at most one");
      end
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        if (rsp1_valid !== 1'(n % 2) || grant_id !== 1'(n % 2) || exp_q.size() == 0 || rsp0_data !== exp_q[0]) begin
          errors++;
          $display("FAIL cont_rsp%0d got port %b gid %b data %h exp port %0d", n, rsp1_valid, grant_id, rsp0_data, n % 2);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        n++;
      end
      acc = req0_ready || req1_ready;
      g = req1_ready;
      if (acc) exp_q.push_back(g ? alu_ref(req1_sel, req1_a, req1_b) : alu_ref(req0_sel, req0_a, req0_b));
      @(negedge clk);
      if (acc && g) begin req1_sel = 4'($urandom_range(0, 8)); req1_a = 8'($urandom); req1_b = 8'($urandom); end
      if (acc && !g) begin req0_sel = 4'($urandom_range(0, 8)); req0_a = 8'($urandom); req0_b = 8'($urandom); end
      #1;
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL cont_count got %0d exp 6", n);
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic test_backpressure();
    int c;
    logic [15:0] e, d;
    do_reset();
    rsp1_ready = 0;
    req1_valid = 1; req1_sel = 4'd8; req1_a = 8'($urandom); req1_b = 8'($urandom);
    e = alu_ref(req1_sel, req1_a, req1_b);
    #1;
    for (c = 0; c < 10 && !req1_ready; c++) begin @(negedge clk); #1; end
    @(negedge clk);
    req1_valid = 0;
    #1;
    for (c = 0; c < 20 && !rsp1_valid; c++) begin @(negedge clk); #1; end
    d = rsp1_data;
    checks++;
    if (rsp1_valid !== 1'b1 || d !== e) begin
      errors++;
      $display("FAIL bp_rsp got valid %b data %h exp valid 1 data %h", rsp1_valid, d, e);
    end
    req0_valid = 1;
    req1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({rsp1_valid, rsp0_valid, rsp1_data, req0_ready, req1_ready, busy} !== {2'b10, d, 3'b001}) begin
        errors++;
        $display("FAIL bp_hold%0d got %h exp %h", k, {rsp1_valid, rsp0_valid, rsp1_data, req0_ready, req1_ready, busy}, {2'b10, d, 3'b001});
      end
    end
    rsp1_ready = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({rsp1_valid, busy, req0_ready, req1_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release got %b exp 0010", {rsp1_valid, busy, req0_ready, req1_ready});
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic test_reset_mid_exec();
    logic saw = 0;
    do_reset();
    rsp0_ready = 1;
    rsp1_ready = 1;
    req0_valid = 1; req0_sel = 4'd1; req0_a = 8'h12; req0_b = 8'h34;
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++;
    if (busy_4 !== 1'b1) begin
      errors++;
      $display("FAIL rst4_exec got %b exp 1", busy_4);
    end
    @(negedge clk);
    rst = 1;
    #1;
    saw |= rsp0_valid_4 | rsp1_valid_4;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({req0_ready_4, req1_ready_4, rsp0_valid_4, rsp1_valid_4, busy_4, grant_id_4, alu_sel_4, alu_a_4, alu_b_4, rsp0_data_4, rsp1_data_4} !== 58'd0) begin
      errors++;
      $display("FAIL rst4_outputs got %h exp 0", {req0_ready_4, req1_ready_4, rsp0_valid_4, rsp1_valid_4, busy_4, grant_id_4, alu_sel_4, alu_a_4, alu_b_4, rsp0_data_4, rsp1_data_4});
    end
    for (int k = 0; k < 8; k++) begin @(negedge clk); #1; saw |= rsp0_valid_4 | rsp1_valid_4; end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL rst4_no_rsp got %b exp 0", saw);
    end
    @(negedge clk);
    req0_valid = 1;
    req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready_4, req1_ready_4} !== 2'b10) begin
      errors++;
      $display("FAIL rst4_ptr got %b exp 10", {req0_ready_4, req1_ready_4});
    end
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic test_operand_isolation();
    int c;
    do_reset();
    rsp0_ready = 1;
    req0_valid = 1; req0_sel = 4'd2; req0_a = 8'h10; req0_b = 8'h03;
    @(negedge clk);
    req0_valid = 0; req0_sel = 4'd4; req0_a = 8'hEE; req0_b = 8'h77;
    for (int k = 0; k < S; k++) begin
      #1;
      checks++;
      if ({alu_sel, alu_a, alu_b} !== {4'd2, 8'h10, 8'h03}) begin
        errors++;
        $display("FAIL iso_ops%0d got %h exp 21003", k, {alu_sel, alu_a, alu_b});
      end
      @(negedge clk);
      req0_a = 8'($urandom);
      req0_b = 8'($urandom);
    end
    #1;
    for (c = 0; c < 10 && !rsp0_valid; c++) begin @(negedge clk); #1; end
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h000D) begin
      errors++;
      $display("FAIL iso_result got valid %b data %h exp valid 1 data 000d", rsp0_valid, rsp0_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int phase = 0, left = 0;
    logic ptr = 0, gid = 0, e0, e1;
    logic [3:0] ls = 0;
    logic [7:0] la = 0, lb = 0;
    logic [15:0] res = 0;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req0_valid = $urandom_range(0, 2) != 0;
      req1_valid = $urandom_range(0, 2) != 0;
      req0_sel = 4'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_sel = 4'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      rsp0_ready = 1'($urandom);
      rsp1_ready = 1'($urandom);
      #1;
      e0 = phase == 0 && req0_valid && (!req1_valid || ptr == 0);
      e1 = phase == 0 && req1_valid && (!req0_valid || ptr == 1);
      checks++;
      if ({req0_ready, req1_ready, busy} !== {e0, e1, phase != 0}) begin
        errors++;
        $display("FAIL rnd_ready c%0d got %b exp %b", c, {req0_ready, req1_ready, busy}, {e0, e1, phase != 0});
      end
      checks++;
      if ({rsp0_valid, rsp1_valid} !== {phase == 2 && !gid, phase == 2 && gid}) begin
        errors++;
        $display("FAIL rnd_rsp_valid c%0d got %b exp %b", c, {rsp0_valid, rsp1_valid}, {phase == 2 && !gid, phase == 2 && gid});
      end
      if (phase != 0) begin
        checks++;
        if ({alu_sel, alu_a, alu_b, grant_id} !== {ls, la, lb, gid}) begin
          errors++;
          $display("FAIL rnd_ops c%0d got %h exp %h", c, {alu_sel, alu_a, alu_b, grant_id}, {ls, la, lb, gid});
        end
      end
      if (phase == 2) begin
        checks++;
        if ((gid ? rsp1_data : rsp0_data) !== res) begin
          errors++;
          $display("FAIL rnd_data c%0d got %h exp %h", c, gid ? rsp1_data : rsp0_data, res);
        end
      end
      if (e0 || e1) begin
        gid = e1;
        ls = e1 ? req1_sel : req0_sel;
        la = e1 ? req1_a : req0_a;
        lb = e1 ? req1_b : req0_b;
        res = alu_ref(ls, la, lb);
        left = S;
        phase = 1;
      end else if (phase == 1) begin
        left--;
        if (left == 0) phase = 2;
      end else if (phase == 2 && (gid ? rsp1_ready : rsp0_ready)) begin
        phase = 0;
        ptr = !gid;
      end
      @(negedge clk);
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_simultaneous();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_operand_isolation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
